// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch and decode stages.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order fetch slots with alloc/fill/pop pointers and flush.
module fetch_buffer import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [XLEN-1:0] i_fill_data,
  input  logic            i_pop,
  output logic [AW:0]     o_count,
  output logic [AW:0]     o_unfilled,
  output logic            o_head_valid,
  output logic [XLEN-1:0] o_head_data,
  output logic [XLEN-1:0] o_head_pc
);
  logic [XLEN-1:0] r_pc [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [AW:0] r_wr, r_fl, r_rd;
  // Entries between r_rd and r_fl are filled, so no per-entry flag is needed.
  assign o_count = r_wr - r_rd;
  assign o_unfilled = r_wr - r_fl;
  assign o_head_valid = r_fl != r_rd;
  assign o_head_data = r_data[r_rd[AW-1:0]];
  assign o_head_pc = r_pc[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr <= '0;
      r_fl <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (AW+1)'(i_alloc);
      r_fl <= r_fl + (AW+1)'(i_fill);
      r_rd <= r_rd + (AW+1)'(i_pop && o_head_valid);
    end
  end
  always_ff @(posedge clk) begin
    if (i_alloc) r_pc[r_wr[AW-1:0]] <= i_alloc_pc;
    if (i_fill) r_data[r_fl[AW-1:0]] <= i_fill_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem request gating and stale-response dropping.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] r_fetch_pc, w_head_data, w_head_pc;
  logic [CW-1:0] r_drop, w_count, w_unfilled;
  logic w_accept, w_fill, w_head_valid;
  // Slots owed to stale responses count against capacity so they never land in fresh entries.
  assign imem_req_valid = rst_n && !redirect_valid && ({1'b0, w_count} + {1'b0, r_drop} < (CW+1)'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_accept = imem_req_valid && imem_req_ready;
  assign w_fill = imem_rsp_valid && r_drop == '0 && !redirect_valid;
  assign instr_valid = w_head_valid;
  assign instr = w_head_valid ? w_head_data : NOP_INSTR;
  assign instr_pc = w_head_valid ? w_head_pc : r_fetch_pc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_drop <= '0;
    end else begin
      r_fetch_pc <= redirect_valid ? word_align(redirect_pc) : r_fetch_pc + (w_accept ? 32'd4 : 32'd0);
      r_drop <= redirect_valid ? r_drop + w_unfilled - CW'(imem_rsp_valid)
                               : r_drop - CW'(imem_rsp_valid && r_drop != '0);
    end
  end
  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (redirect_valid),
    .i_alloc      (w_accept),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_data  (imem_rsp_data),
    .i_pop        (instr_ready),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_data),
    .o_head_pc    (w_head_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, hand sequences and a random run against a PC-stream reference.
module tb_fetch_unit;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0;
  logic instr_valid, instr_ready = 0;
  logic [31:0] imem_addr, imem_rsp_data = '0, redirect_pc = '0, instr, instr_pc;
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );
  typedef struct {logic [31:0] addr; int due; int ep;} req_t;
  typedef struct packed {logic [2:0] f; logic [31:0] rpc; logic [1:0] e; logic [31:0] ea, ep;} vec_t;
  req_t mq[$];
  vec_t tbl [29];
  int checks = 0, errors = 0, cyc = 0, epoch = 0, held = 0, last_due = 0, pops = 0;
  int lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_pc = '0, exp_req = '0;
  logic hold = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  function automatic vec_t v(input logic [2:0] f, input logic [31:0] rpc, input logic [1:0] e,
                             input logic [31:0] ea, input logic [31:0] ep);
    return {f, rpc, e, ea, ep};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0;
    imem_req_ready = 1; instr_ready = 1; redirect_valid = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    mq.delete();
    repeat (3) step();
    chkb("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chkb("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_instr_pc", instr_pc, 32'h0);
    rst_n = 1;
    exp_pc = '0; exp_req = '0; held = 0; hold = 0; last_due = cyc;
  endtask
  // Drives one cycle's inputs, plays the memory, and checks outputs against the model.
  task automatic drive(input logic rr, input logic ir, input logic rv, input logic [31:0] rpc);
    int stale, lat;
    req_t r;
    logic cur_stale;
    imem_req_ready = rr; instr_ready = ir; redirect_valid = rv; redirect_pc = rpc;
    imem_rsp_valid = 0; imem_rsp_data = '0; cur_stale = 0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_rsp_valid = 1;
      imem_rsp_data = mem_word(r.addr);
      cur_stale = r.ep != epoch;
    end
    #1;
    stale = int'(cur_stale);
    foreach (mq[k]) if (mq[k].ep != epoch) stale++;
    chkb("req_valid", imem_req_valid, !rv && (held + stale < DEPTH));
    if (imem_req_valid) chk("req_addr", imem_addr, exp_req);
    if (hold) chkb("hold_valid", instr_valid, 1'b1);
    if (instr_valid) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, mem_word(exp_pc));
    end else chk("nop", instr, NOP_INSTR);
    hold = instr_valid && !ir && !rv;
    if (instr_valid && ir) begin
      exp_pc += 4; held--; pops++;
    end
    if (imem_req_valid && rr) begin
      lat = $urandom_range(lat_hi, lat_lo);
      r.addr = exp_req;
      r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      r.ep = epoch;
      last_due = r.due;
      mq.push_back(r);
      held++;
      exp_req += 4;
    end
    if (rv) begin
      epoch++; held = 0;
      exp_pc = rpc & ~32'h3;
      exp_req = exp_pc;
    end
  endtask
  initial begin
    tbl[0]  = v(3'b100, 32'h0, 2'b10, 32'h0, 32'h0);
    tbl[1]  = v(3'b100, 32'h0, 2'b10, 32'h4, 32'h0);
    tbl[2]  = v(3'b100, 32'h0, 2'b11, 32'h8, 32'h0);
    tbl[3]  = v(3'b100, 32'h0, 2'b11, 32'hC, 32'h0);
    for (int i = 4; i < 10; i++) tbl[i] = v(3'b100, 32'h0, 2'b01, 32'h10, 32'h0);
    tbl[10] = v(3'b110, 32'h0, 2'b01, 32'h10, 32'h0);
    tbl[11] = v(3'b110, 32'h0, 2'b11, 32'h10, 32'h4);
    tbl[12] = v(3'b110, 32'h0, 2'b11, 32'h14, 32'h8);
    tbl[13] = v(3'b110, 32'h0, 2'b11, 32'h18, 32'hC);
    tbl[14] = v(3'b111, 32'h103, 2'b01, 32'h1C, 32'h10);
    tbl[15] = v(3'b110, 32'h0, 2'b10, 32'h100, 32'h0);
    tbl[16] = v(3'b110, 32'h0, 2'b10, 32'h104, 32'h0);
    tbl[17] = v(3'b110, 32'h0, 2'b11, 32'h108, 32'h100);
    tbl[18] = v(3'b110, 32'h0, 2'b11, 32'h10C, 32'h104);
    tbl[19] = v(3'b111, 32'hFFFF_FFF8, 2'b01, 32'h110, 32'h108);
    tbl[20] = v(3'b110, 32'h0, 2'b10, 32'hFFFF_FFF8, 32'h0);
    tbl[21] = v(3'b110, 32'h0, 2'b10, 32'hFFFF_FFFC, 32'h0);
    tbl[22] = v(3'b110, 32'h0, 2'b11, 32'h0, 32'hFFFF_FFF8);
    tbl[23] = v(3'b110, 32'h0, 2'b11, 32'h4, 32'hFFFF_FFFC);
    tbl[24] = v(3'b010, 32'h0, 2'b11, 32'h8, 32'h0);
    tbl[25] = v(3'b010, 32'h0, 2'b11, 32'h8, 32'h4);
    tbl[26] = v(3'b110, 32'h0, 2'b10, 32'h8, 32'h0);
    tbl[27] = v(3'b110, 32'h0, 2'b10, 32'hC, 32'h0);
    tbl[28] = v(3'b110, 32'h0, 2'b11, 32'h10, 32'h8);
    do_reset();
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].f[2], tbl[i].f[1], tbl[i].f[0], tbl[i].rpc);
      chkb("t_req_valid", imem_req_valid, tbl[i].e[1]);
      chk("t_addr", imem_addr, tbl[i].ea);
      chkb("t_instr_valid", instr_valid, tbl[i].e[0]);
      if (tbl[i].e[0]) chk("t_instr_pc", instr_pc, tbl[i].ep);
      step();
    end
    lat_lo = 3; lat_hi = 3;
    repeat (8) begin drive(1, 1, 0, 0); step(); end
    drive(1, 1, 1, 32'h100);
    step();
    drive(1, 1, 0, 0);
    chk("redir_addr", imem_addr, 32'h100);
    step();
    repeat (15) begin drive(1, 1, 0, 0); step(); end
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      logic rv;
      logic [31:0] t;
      rv = $urandom_range(99, 0) < 3;
      t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7, rv, t);
      step();
      if (i == 1500) do_reset();
    end
    repeat (30) begin drive(1, 1, 0, 0); step(); end
    chkb("progress", pops > 300, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
